// File: rtl/io_port_pkg.sv
// Shared constants for the parametrised GPIO port: register map, edge-mode encodings
// and the default shared-bus width.
package io_port_pkg;

    localparam int BUS_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        ADDR_DATA_OUT   = 3'd0,
        ADDR_DIR        = 3'd1,
        ADDR_PIN_IN     = 3'd2,
        ADDR_IRQ_EN     = 3'd3,
        ADDR_IRQ_MODE   = 3'd4,
        ADDR_IRQ_STATUS = 3'd5,
        ADDR_DATA_SET   = 3'd6,
        ADDR_DATA_CLR   = 3'd7
    } io_addr_e;

    localparam logic MODE_RISE = 1'b0;
    localparam logic MODE_FALL = 1'b1;

endpackage

// File: rtl/io_sync.sv
// N-stage per-bit synchroniser for asynchronous pad inputs; synchronous active-high reset.
module io_sync #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) sync_q <= '0;
        else         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/io_port_gpio.sv
// Bidirectional GPIO port on a shared tri-state bus: per-pin direction, atomic set/clear,
// synchronised inputs and sticky edge-triggered interrupts.
module io_port_gpio
    import io_port_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int BUS_W       = BUS_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    inout  wire  [BUS_W-1:0] bus,
    input  logic [2:0]       addr,
    input  logic             rEn,
    input  logic             wEn,
    input  logic [WIDTH-1:0] pins_in,
    output logic [WIDTH-1:0] pins_out,
    output logic [WIDTH-1:0] pins_oe,
    output logic             irq
);

    logic [WIDTH-1:0] out_q, out_d, dir_q, dir_d, en_q, en_d;
    logic [WIDTH-1:0] mode_q, mode_d, status_q, status_d, prev_q;
    logic [WIDTH-1:0] sync_w, wdata, w1c, edge_w, rdata;

    io_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i   (clk),
        .reset_i (reset),
        .d_i     (pins_in),
        .q_o     (sync_w)
    );

    assign wdata = bus[WIDTH-1:0];

    always_comb begin
        for (int i = 0; i < WIDTH; i++)
            edge_w[i] = (mode_q[i] == MODE_FALL) ? (~sync_w[i] & prev_q[i])
                                                 : (sync_w[i] & ~prev_q[i]);
    end

    always_comb begin
        out_d  = out_q;
        dir_d  = dir_q;
        en_d   = en_q;
        mode_d = mode_q;
        w1c    = '0;
        if (wEn) begin
            case (io_addr_e'(addr))
                ADDR_DATA_OUT:   out_d  = wdata;
                ADDR_DIR:        dir_d  = wdata;
                ADDR_PIN_IN:     ;
                ADDR_IRQ_EN:     en_d   = wdata;
                ADDR_IRQ_MODE:   mode_d = wdata;
                ADDR_IRQ_STATUS: w1c    = wdata;
                ADDR_DATA_SET:   out_d  = out_q | wdata;
                ADDR_DATA_CLR:   out_d  = out_q & ~wdata;
            endcase
        end
        // a new edge in the same cycle as a W1C keeps the bit set
        status_d = (status_q & ~w1c) | (edge_w & en_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q    <= '0;
            dir_q    <= '0;
            en_q     <= '0;
            mode_q   <= '0;
            status_q <= '0;
            prev_q   <= '0;
        end else begin
            out_q    <= out_d;
            dir_q    <= dir_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            status_q <= status_d;
            prev_q   <= sync_w;
        end
    end

    always_comb begin
        rdata = '0;
        case (io_addr_e'(addr))
            ADDR_DATA_OUT:   rdata = out_q;
            ADDR_DIR:        rdata = dir_q;
            ADDR_PIN_IN:     rdata = sync_w;
            ADDR_IRQ_EN:     rdata = en_q;
            ADDR_IRQ_MODE:   rdata = mode_q;
            ADDR_IRQ_STATUS: rdata = status_q;
            ADDR_DATA_SET:   rdata = '0;
            ADDR_DATA_CLR:   rdata = '0;
        endcase
    end

    assign bus      = (rEn && !wEn) ? BUS_W'(rdata) : {BUS_W{1'bz}};
    assign pins_out = out_q;
    assign pins_oe  = dir_q;
    assign irq      = |(status_q & en_q);

endmodule

// File: tb/tb_io_port_gpio.sv
// Directed bench for io_port_gpio: stimulus pushes expectations into a scoreboard queue,
// a negedge monitor pops and compares them against the live DUT outputs.
module tb_io_port_gpio;

    localparam int K_BUS = 0, K_OUT = 1, K_OE = 2, K_IRQ = 3;

    typedef struct {
        int          kind;
        logic [15:0] exp;
        string       name;
    } exp_t;

    logic        clk, reset, rEn, wEn, drv_en;
    logic [15:0] drv, pins_in, pins_out, pins_oe;
    logic [2:0]  addr;
    logic        irq;
    wire  [15:0] bus;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;

    assign bus = drv_en ? drv : 16'hzzzz;

    io_port_gpio #(.WIDTH(16), .BUS_W(16), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .addr     (addr),
        .rEn      (rEn),
        .wEn      (wEn),
        .pins_in  (pins_in),
        .pins_out (pins_out),
        .pins_oe  (pins_oe),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // monitor: compare every queued expectation at the falling edge
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t        e;
            logic [15:0] act;
            e = sb.pop_front();
            case (e.kind)
                K_BUS:   act = bus;
                K_OUT:   act = pins_out;
                K_OE:    act = pins_oe;
                default: act = {15'b0, irq};
            endcase
            n_vec++;
            if (act !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input logic [15:0] exp, input string name);
        exp_t e;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic chk(input int kind, input logic [15:0] exp, input string name);
        push(kind, exp, name);
        tick();
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        addr = a; drv = d; drv_en = 1'b1; wEn = 1'b1; rEn = 1'b0;
        tick();
        wEn = 1'b0; drv_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string name);
        addr = a; rEn = 1'b1;
        push(K_BUS, exp, name);
        tick();
        rEn = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rEn = 1'b0; wEn = 1'b0; drv_en = 1'b0; drv = '0;
        addr = '0; pins_in = '0;
        tick(); tick();
        reset = 1'b0;

        // defaults after reset
        for (int a = 0; a < 8; a++) rd(3'(a), 16'h0000, $sformatf("reset_rd%0d", a));
        chk(K_OE,  16'h0000, "reset_oe");
        chk(K_IRQ, 16'h0000, "reset_irq");
        chk(K_OUT, 16'h0000, "reset_out");

        // data register and atomic set/clear
        wr(3'd0, 16'h00F0); chk(K_OUT, 16'h00F0, "write_data");
        wr(3'd6, 16'h0F01); chk(K_OUT, 16'h0FF1, "set_data");
        wr(3'd7, 16'h0011); chk(K_OUT, 16'h0FE0, "clr_data");
        rd(3'd6, 16'h0000, "rd_set_reg");
        rd(3'd7, 16'h0000, "rd_clr_reg");
        rd(3'd0, 16'h0FE0, "rd_data");
        wr(3'd1, 16'h00FF); chk(K_OE, 16'h00FF, "dir_oe");
        rd(3'd1, 16'h00FF, "rd_dir");

        // no drive while rEn=0: the bench's own 0x0000 must be all that is on the bus
        addr = 3'd0; drv = 16'h0000; drv_en = 1'b1;
        chk(K_BUS, 16'h0000, "bus_idle_hiz");
        drv_en = 1'b0;

        // input synchroniser latency
        pins_in = 16'hA5A5;
        rd(3'd2, 16'h0000, "pin_lat0");
        rd(3'd2, 16'h0000, "pin_lat1");
        rd(3'd2, 16'hA5A5, "pin_lat2");
        pins_in = 16'h0000;
        repeat (4) tick();

        // rising on pin0, falling on pin1
        wr(3'd3, 16'h0003);
        wr(3'd4, 16'h0002);
        pins_in = 16'h0002;
        repeat (4) tick();
        rd(3'd5, 16'h0000, "no_status_on_rise_pin1");
        pins_in = 16'h0003;
        tick(); tick();
        rd(3'd5, 16'h0000, "status_before_edge");
        rd(3'd5, 16'h0001, "status_rise_pin0");
        chk(K_IRQ, 16'h0001, "irq_rise");
        pins_in = 16'h0001;
        repeat (3) tick();
        rd(3'd5, 16'h0003, "status_fall_pin1");
        wr(3'd5, 16'h0001);
        rd(3'd5, 16'h0002, "status_w1c");
        chk(K_IRQ, 16'h0001, "irq_after_w1c");
        wr(3'd3, 16'h0000);
        chk(K_IRQ, 16'h0000, "irq_masked");
        rd(3'd5, 16'h0002, "status_kept_masked");
        wr(3'd3, 16'h0003);
        chk(K_IRQ, 16'h0001, "irq_unmasked");
        wr(3'd5, 16'h0003);
        chk(K_IRQ, 16'h0000, "irq_cleared");

        // W1C lands in the same cycle as a new rising edge on pin0
        pins_in = 16'h0000;
        repeat (4) tick();
        rd(3'd5, 16'h0000, "status_pre_collide");
        pins_in = 16'h0001;
        tick(); tick();
        wr(3'd5, 16'h0001);
        rd(3'd5, 16'h0001, "w1c_collision");
        wr(3'd5, 16'h0001);
        rd(3'd5, 16'h0000, "w1c_after_collision");

        // simultaneous read and write: write wins, port stays off the bus
        addr = 3'd0; drv = 16'h1234; drv_en = 1'b1; wEn = 1'b1; rEn = 1'b1;
        push(K_BUS, 16'h1234, "bus_contention");
        tick();
        wEn = 1'b0; rEn = 1'b0; drv_en = 1'b0;
        chk(K_OUT, 16'h1234, "rw_write_wins");

        // raise irq, then reset during a write
        pins_in = 16'h0003; repeat (4) tick();
        pins_in = 16'h0001; repeat (4) tick();
        chk(K_IRQ, 16'h0001, "irq_before_reset");
        reset = 1'b1; addr = 3'd0; drv = 16'hBEEF; drv_en = 1'b1; wEn = 1'b1;
        tick();
        reset = 1'b0; wEn = 1'b0; drv_en = 1'b0;
        chk(K_OUT, 16'h0000, "reset_beats_write");
        chk(K_IRQ, 16'h0000, "reset_irq_mid");
        chk(K_OE,  16'h0000, "reset_oe_mid");
        repeat (4) tick();
        rd(3'd5, 16'h0000, "pin_high_through_reset");

        repeat (4) begin
            if (sb.size() > 0) tick();
        end
        if (sb.size() > 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
